multichannel_mem: RTL and testbench
===================================

MULTICHANNEL_MEM -- requirements
Module: multichannel_mem

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, word-address width; depth is 2**ADDR_BITS words.
REQ-002 SHALL have parameter DATA_BITS, default 8, word width.
REQ-003 SHALL have parameter CHANNELS, default 4, number of independent request channels (1..16).
REQ-004 SHALL have parameter LATENCY, default 2, cycles from grant to the ready pulse (1..15).
REQ-005 SHALL have parameter WRITABLE, default 1; when 0, write ports are ignored and write_ready stays 0.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 mem_read_valid  input  CHANNELS  per-channel read request.
REQ-009 mem_read_address  input  CHANNELS*ADDR_BITS  packed read addresses; channel i occupies bits [i*ADDR_BITS +: ADDR_BITS].
REQ-010 mem_read_ready  output  CHANNELS  per-channel read-complete pulse.
REQ-011 mem_read_data  output  CHANNELS*DATA_BITS  packed read data; valid while the channel's ready is 1.
REQ-012 mem_write_valid  input  CHANNELS  per-channel write request.
REQ-013 mem_write_address  input  CHANNELS*ADDR_BITS  packed write addresses.
REQ-014 mem_write_data  input  CHANNELS*DATA_BITS  packed write data.
REQ-015 mem_write_ready  output  CHANNELS  per-channel write-complete pulse.
REQ-016 load_en  input  1  backdoor preload strobe.
REQ-017 load_addr  input  ADDR_BITS  preload address.
REQ-018 load_data  input  DATA_BITS  preload data.
REQ-019 busy  output  1  1 while any channel is not IDLE.

Function
REQ-020 Storage SHALL be a single array with one access per cycle: at most one backdoor load or one channel grant per cycle.
REQ-021 Each channel SHALL run its own FSM: IDLE -> WAIT (granted, counting) -> RESP (ready=1 for exactly one cycle) -> DROP (waiting for valid to fall) -> IDLE.
REQ-022 An IDLE channel with read_valid or write_valid set SHALL request the array; a channel asserting both SHALL be served as a write first, and the read SHALL be served after the write completes.
REQ-023 Arbitration SHALL be round-robin: the search starts at the channel after the last granted channel; after reset the search starts at channel 0.
REQ-024 On grant, a read SHALL sample array[address] into the channel's data register; a write SHALL update array[address] in the same edge (only when WRITABLE=1).
REQ-025 The ready pulse SHALL assert exactly LATENCY cycles after the grant edge, for exactly one cycle; mem_read_data SHALL hold the sampled word from that cycle until the next read grant on that channel.
REQ-026 In DROP, the channel SHALL return to IDLE in the first cycle its valid is sampled 0; a valid held high SHALL never cause a second access.
REQ-027 load_en SHALL take priority over grants: the array write happens that edge and no channel is granted that cycle; WAIT counters SHALL keep running.
REQ-028 Ordering SHALL follow grant order: a read granted after a write to the same address returns the new data; a read granted in the same cycle as a load returns the old data.
REQ-029 Addresses SHALL be used modulo 2**ADDR_BITS; no out-of-range condition exists.
REQ-030 With WRITABLE=0, write_valid SHALL be ignored and the channel SHALL behave as though only read_valid existed.

Reset
REQ-031 While reset=1: all FSMs go to IDLE; mem_read_ready=0, mem_write_ready=0, mem_read_data=0, busy=0; the round-robin pointer returns to channel 0.
REQ-032 Array contents SHALL NOT be cleared by reset.
REQ-033 Reset mid-operation SHALL abort in-flight requests with no ready pulse; a write already granted stays committed.
REQ-034 load_en SHALL be honoured during reset, so the bench can preload before release.

Verification
REQ-035 Preload array[0..15]={0..7,0..7} during reset; after release, ch0 reads addr 9 with valid held -> ready pulses exactly 2 cycles after the grant with data 1, one pulse only.
REQ-036 All 4 channels raise read_valid in the same cycle at addrs 0..3 -> grants go to ch0,1,2,3 on consecutive cycles; the ready pulses are staggered one cycle apart; data 0,1,2,3.
REQ-037 ch1 writes 8'hAA to addr 16, then ch2 reads addr 16 granted later -> ch2 gets 8'hAA; a read granted before the write gets the old value.
REQ-038 load_en asserted for 3 cycles while ch0 is requesting -> no grant during those cycles; ch0 is granted the cycle after the last load.
REQ-039 Reset asserted while ch3 is in WAIT -> no read_ready[3] pulse, busy=0 the next cycle; a later request succeeds normally.
REQ-040 WRITABLE=0: a write to addr 5 -> write_ready stays 0 and array[5] is unchanged when read back.

Source files
------------

// File: rtl/multichannel_mem.sv
// Multichannel memory: one shared word array served to several request
// channels through a round-robin arbiter, one access per cycle. Each channel
// runs a small IDLE/WAIT/RESP/DROP handshake with a fixed response latency.
// A backdoor load port preloads the array and always wins over channel grants.
module multichannel_mem #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int CHANNELS  = 4,
  parameter int LATENCY   = 2,
  parameter int WRITABLE  = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            mem_read_valid,
  input  logic [CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  output logic [CHANNELS-1:0]            mem_read_ready,
  output logic [CHANNELS*DATA_BITS-1:0]  mem_read_data,
  input  logic [CHANNELS-1:0]            mem_write_valid,
  input  logic [CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  input  logic [CHANNELS*DATA_BITS-1:0]  mem_write_data,
  output logic [CHANNELS-1:0]            mem_write_ready,
  input  logic                           load_en,
  input  logic [ADDR_BITS-1:0]           load_addr,
  input  logic [DATA_BITS-1:0]           load_data,
  output logic                           busy
);

  localparam int DEPTH   = 2 ** ADDR_BITS;
  localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DROP} state_t;

  state_t                          state      [CHANNELS];
  state_t                          state_next [CHANNELS];
  logic [3:0]                      count      [CHANNELS];
  logic [3:0]                      count_next [CHANNELS];
  logic [CHANNELS-1:0]             op_write;
  logic [CHANNELS-1:0]             op_write_next;

  logic [DATA_BITS-1:0]            mem [DEPTH];
  logic [CHANNELS*DATA_BITS-1:0]   read_data_q;
  logic [CH_BITS-1:0]              rr_ptr;

  logic [CHANNELS-1:0]             write_req;
  logic [CHANNELS-1:0]             request;
  logic                            grant_valid;
  logic [CH_BITS-1:0]              grant_idx;
  logic                            grant_write;
  logic [ADDR_BITS-1:0]            grant_read_addr;
  logic [ADDR_BITS-1:0]            grant_write_addr;
  logic [DATA_BITS-1:0]            grant_write_data;

  // Channel index arithmetic modulo the channel count.
  function automatic logic [CH_BITS-1:0] wrap(input int value);
    int m;
    m = value % CHANNELS;
    return m[CH_BITS-1:0];
  endfunction

  // A read-only instance never sees write requests at all.
  assign write_req = (WRITABLE != 0) ? mem_write_valid : '0;

  assign grant_write      = write_req[grant_idx];
  assign grant_read_addr  = mem_read_address[int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
  assign grant_write_addr = mem_write_address[int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
  assign grant_write_data = mem_write_data[int'(grant_idx)*DATA_BITS +: DATA_BITS];
  assign mem_read_data    = reset ? '0 : read_data_q;

  // Only idle channels compete for the array.
  always_comb begin
    request = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      request[i] = (state[i] == IDLE) && (mem_read_valid[i] || write_req[i]);
    end
  end

  // Round-robin pick starting at the channel after the last grant; a load or reset blocks it.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!grant_valid && request[wrap(int'(rr_ptr) + k)]) begin
        grant_valid = 1'b1;
        grant_idx   = wrap(int'(rr_ptr) + k);
      end
    end
    if (load_en || reset) begin
      grant_valid = 1'b0;
    end
  end

  // Per-channel handshake next state: count down the latency, pulse once, wait for valid to drop.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_next[i]    = state[i];
      count_next[i]    = count[i];
      op_write_next[i] = op_write[i];
      case (state[i])
        IDLE: begin
          if (grant_valid && int'(grant_idx) == i) begin
            state_next[i]    = WAIT;
            count_next[i]    = 4'(LATENCY - 1);
            op_write_next[i] = grant_write;
          end
        end
        WAIT: begin
          if (count[i] == 4'd0) begin
            state_next[i] = RESP;
          end else begin
            count_next[i] = count[i] - 4'd1;
          end
        end
        RESP: state_next[i] = DROP;
        DROP: begin
          if (op_write[i] ? !write_req[i] : !mem_read_valid[i]) begin
            state_next[i] = IDLE;
          end
        end
        default: state_next[i] = IDLE;
      endcase
    end
  end

  // Channel state registers; reset drops every in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state[i] <= IDLE;
        count[i] <= '0;
      end
      op_write <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state[i] <= state_next[i];
        count[i] <= count_next[i];
      end
      op_write <= op_write_next;
    end
  end

  // Array writes: backdoor load first, otherwise a granted channel write; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (grant_valid && grant_write) begin
      mem[grant_write_addr] <= grant_write_data;
    end
  end

  // Granted reads capture the word now and hold it until that channel's next read grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q <= '0;
    end else if (grant_valid && !grant_write) begin
      read_data_q[int'(grant_idx)*DATA_BITS +: DATA_BITS] <= mem[grant_read_addr];
    end
  end

  // Round-robin pointer advances past each granted channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= wrap(int'(grant_idx) + 1);
    end
  end

  // Completion pulses and busy flag, forced low while reset is held.
  always_comb begin
    mem_read_ready  = '0;
    mem_write_ready = '0;
    busy            = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!reset && state[i] == RESP) begin
        mem_read_ready[i]  = !op_write[i];
        mem_write_ready[i] = op_write[i];
      end
      if (!reset && state[i] != IDLE) begin
        busy = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multichannel_mem.sv
// Self-checking bench for multichannel_mem: a scoreboard of expected ready
// pulses (channel, kind, data, cycle) is filled as requests are driven and
// drained by a monitor sampling on the falling clock edge.
module tb_multichannel_mem;

  localparam int CH  = 4;
  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int LAT = 2;

  typedef struct {
    int         dut;
    int         ch;
    bit         wr;
    logic [7:0] data;
    int         due;
  } sb_t;

  typedef struct {
    int         ch;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic                load_en;
  logic [AB-1:0]       load_addr;
  logic [DB-1:0]       load_data;

  logic [CH-1:0]       rv, wv, rready, wready;
  logic [CH*AB-1:0]    raddr, waddr;
  logic [CH*DB-1:0]    wdata, rdata;
  logic                busy;

  logic [CH-1:0]       ro_rv, ro_wv, ro_rready, ro_wready;
  logic [CH*AB-1:0]    ro_raddr, ro_waddr;
  logic [CH*DB-1:0]    ro_wdata, ro_rdata;
  logic                ro_busy;

  multichannel_mem #(.ADDR_BITS(AB), .DATA_BITS(DB), .CHANNELS(CH), .LATENCY(LAT), .WRITABLE(1)) dut (
    .clk(clk), .reset(reset),
    .mem_read_valid(rv), .mem_read_address(raddr), .mem_read_ready(rready), .mem_read_data(rdata),
    .mem_write_valid(wv), .mem_write_address(waddr), .mem_write_data(wdata), .mem_write_ready(wready),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy)
  );

  multichannel_mem #(.ADDR_BITS(AB), .DATA_BITS(DB), .CHANNELS(CH), .LATENCY(LAT), .WRITABLE(0)) dut_ro (
    .clk(clk), .reset(reset),
    .mem_read_valid(ro_rv), .mem_read_address(ro_raddr), .mem_read_ready(ro_rready), .mem_read_data(ro_rdata),
    .mem_write_valid(ro_wv), .mem_write_address(ro_waddr), .mem_write_data(ro_wdata), .mem_write_ready(ro_wready),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(ro_busy)
  );

  int   n_checks = 0;
  int   n_passed = 0;
  int   cyc      = 0;
  sb_t  sb[$];
  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic pushExp(input int d, input int ch, input bit wr, input logic [7:0] data, input int due);
    sb.push_back('{d, ch, wr, data, due});
  endtask

  task automatic matchPulse(input int d, input int ch, input bit wr, input logic [7:0] data);
    int idx;
    idx = -1;
    foreach (sb[k]) begin
      if (idx < 0 && sb[k].dut == d && sb[k].ch == ch && sb[k].wr == wr) idx = k;
    end
    if (idx < 0) begin
      n_checks++;
      $display("[TB] FAIL unexpected_pulse: dut %0d ch %0d write %0d seen at cycle %0d, expected no pulse",
               d, ch, wr, cyc);
    end else begin
      checkOutput($sformatf("pulse_cycle d%0d ch%0d w%0d", d, ch, wr), 32'(cyc), 32'(sb[idx].due));
      if (!wr) checkOutput($sformatf("read_data d%0d ch%0d", d, ch), 32'(data), 32'(sb[idx].data));
      sb.delete(idx);
    end
  endtask

  task automatic monitorOutputs();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < CH; i++) begin
        logic rr, ww;
        logic [7:0] rd;
        rr = (d == 0) ? rready[i] : ro_rready[i];
        ww = (d == 0) ? wready[i] : ro_wready[i];
        rd = (d == 0) ? rdata[i*DB +: DB] : ro_rdata[i*DB +: DB];
        if (rr === 1'b1) matchPulse(d, i, 1'b0, rd);
        if (ww === 1'b1) matchPulse(d, i, 1'b1, rd);
      end
    end
  endtask

  // One clock: sample outputs on the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitorOutputs();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("[TB] FAIL drain_timeout: %0d pulses still outstanding at cycle %0d, expected 0", sb.size(), cyc);
      sb.delete();
    end
  endtask

  task automatic setRead(input int d, input int ch, input bit v, input logic [7:0] a);
    if (d == 0) begin rv[ch] = v; raddr[ch*AB +: AB] = a; end
    else begin ro_rv[ch] = v; ro_raddr[ch*AB +: AB] = a; end
  endtask

  task automatic setWrite(input int d, input int ch, input bit v, input logic [7:0] a, input logic [7:0] w);
    if (d == 0) begin wv[ch] = v; waddr[ch*AB +: AB] = a; wdata[ch*DB +: DB] = w; end
    else begin ro_wv[ch] = v; ro_waddr[ch*AB +: AB] = a; ro_wdata[ch*DB +: DB] = w; end
  endtask

  task automatic clearRequests();
    rv = '0; wv = '0; ro_rv = '0; ro_wv = '0;
  endtask

  task automatic resetPulse();
    clearRequests();
    reset = 1'b1;
    tick();
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_read_data", rdata, 32'd0);
    tick();
    reset = 1'b0;
    tick();
  endtask

  // One isolated transaction on an idle main instance, then release and check the held data.
  task automatic applyStimulus(input vec_t v);
    if (v.wr) begin
      setWrite(0, v.ch, 1'b1, v.addr, v.wdata);
      pushExp(0, v.ch, 1'b1, 8'h00, cyc + 1 + LAT);
    end else begin
      setRead(0, v.ch, 1'b1, v.addr);
      pushExp(0, v.ch, 1'b0, v.exp, cyc + 1 + LAT);
    end
    waitDrain(20);
    clearRequests();
    tick();
    tick();
    if (!v.wr) checkOutput($sformatf("table_hold ch%0d", v.ch), 32'(rdata[v.ch*DB +: DB]), 32'(v.exp));
  endtask

  initial begin
    vecs[0] = '{1, 1'b1, 8'hFF, 8'h5A, 8'h00};
    vecs[1] = '{3, 1'b0, 8'hFF, 8'h00, 8'h5A};
    vecs[2] = '{0, 1'b0, 8'd41, 8'h00, 8'h71};
    vecs[3] = '{2, 1'b0, 8'd20, 8'h00, 8'h3C};
    vecs[4] = '{0, 1'b1, 8'd3,  8'h33, 8'h00};
    vecs[5] = '{1, 1'b0, 8'd3,  8'h00, 8'h33};
    vecs[6] = '{2, 1'b0, 8'd15, 8'h00, 8'h07};
    vecs[7] = '{3, 1'b0, 8'd16, 8'h00, 8'hAA};

    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    rv = '0; raddr = '0; wv = '0; waddr = '0; wdata = '0;
    ro_rv = '0; ro_raddr = '0; ro_wv = '0; ro_waddr = '0; ro_wdata = '0;

    // Preload 0..7,0..7 plus a marker at 16 while reset is held.
    for (int a = 0; a < 17; a++) begin
      load_en = 1'b1;
      load_addr = 8'(a);
      load_data = (a < 16) ? 8'(a % 8) : 8'h55;
      tick();
    end
    load_en = 1'b0;
    tick();
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_read_ready", 32'(rready), 32'd0);
    checkOutput("reset_write_ready", 32'(wready), 32'd0);
    checkOutput("reset_read_data", rdata, 32'd0);
    checkOutput("reset_ro_busy", 32'(ro_busy), 32'd0);
    reset = 1'b0;
    tick();

    // Single read with valid held long past the pulse.
    setRead(0, 0, 1'b1, 8'd9);
    pushExp(0, 0, 1'b0, 8'd1, cyc + 1 + LAT);
    waitDrain(20);
    repeat (4) tick();
    checkOutput("held_valid_busy", 32'(busy), 32'd1);
    checkOutput("held_valid_data", 32'(rdata[7:0]), 32'd1);
    clearRequests();
    tick();
    tick();
    checkOutput("dropped_busy", 32'(busy), 32'd0);

    // All four channels at once: grants 0,1,2,3 on consecutive edges.
    resetPulse();
    for (int c = 0; c < CH; c++) begin
      setRead(0, c, 1'b1, 8'(c));
      pushExp(0, c, 1'b0, 8'(c), cyc + 1 + LAT + c);
    end
    waitDrain(30);
    clearRequests();
    tick();
    tick();

    // Read granted before a write sees the old word; a later read sees the new one.
    resetPulse();
    setRead(0, 2, 1'b1, 8'd16);
    pushExp(0, 2, 1'b0, 8'h55, cyc + 1 + LAT);
    tick();
    setWrite(0, 1, 1'b1, 8'd16, 8'hAA);
    pushExp(0, 1, 1'b1, 8'h00, cyc + 1 + LAT);
    waitDrain(20);
    clearRequests();
    tick();
    tick();
    setRead(0, 2, 1'b1, 8'd16);
    pushExp(0, 2, 1'b0, 8'hAA, cyc + 1 + LAT);
    waitDrain(20);
    clearRequests();
    tick();
    tick();

    // Read and write together on one channel: write first, read after write valid falls.
    setWrite(0, 3, 1'b1, 8'd20, 8'h3C);
    setRead(0, 3, 1'b1, 8'd20);
    pushExp(0, 3, 1'b1, 8'h00, cyc + 1 + LAT);
    waitDrain(20);
    setWrite(0, 3, 1'b0, 8'd20, 8'h3C);
    pushExp(0, 3, 1'b0, 8'h3C, cyc + 2 + LAT);
    waitDrain(20);
    clearRequests();
    tick();
    tick();

    // Three back-to-back loads block the pending request until the cycle after the last one.
    setRead(0, 0, 1'b1, 8'd2);
    pushExp(0, 0, 1'b0, 8'd2, cyc + 4 + LAT);
    for (int k = 0; k < 3; k++) begin
      load_en = 1'b1;
      load_addr = 8'(40 + k);
      load_data = 8'(8'h70 + k);
      tick();
      checkOutput($sformatf("load_blocks_grant %0d", k), 32'(busy), 32'd0);
    end
    load_en = 1'b0;
    tick();
    checkOutput("grant_after_load", 32'(busy), 32'd1);
    waitDrain(20);
    clearRequests();
    tick();
    tick();

    for (int v = 0; v < 8; v++) applyStimulus(vecs[v]);

    // Reset while channel 3 waits: no pulse, then a fresh request completes.
    resetPulse();
    setRead(0, 3, 1'b1, 8'd6);
    tick();
    checkOutput("ch3_wait_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    setRead(0, 3, 1'b0, 8'd6);
    tick();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ready", 32'(rready[3]), 32'd0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    checkOutput("after_abort_busy", 32'(busy), 32'd0);
    setRead(0, 3, 1'b1, 8'd6);
    pushExp(0, 3, 1'b0, 8'd6, cyc + 1 + LAT);
    waitDrain(20);
    clearRequests();
    tick();
    tick();

    // Read-only instance: writes ignored, array untouched.
    setWrite(1, 0, 1'b1, 8'd5, 8'hEE);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("ro_write_ready %0d", k), 32'(ro_wready), 32'd0);
      checkOutput($sformatf("ro_busy %0d", k), 32'(ro_busy), 32'd0);
    end
    clearRequests();
    tick();
    setRead(1, 1, 1'b1, 8'd5);
    setWrite(1, 1, 1'b1, 8'd5, 8'hEE);
    pushExp(1, 1, 1'b0, 8'd5, cyc + 1 + LAT);
    waitDrain(20);
    clearRequests();
    tick();
    tick();
    checkOutput("ro_hold_data", 32'(ro_rdata[DB +: DB]), 32'd5);

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
